npc_queue: RTL

//  Parametrised fetch-address queue between next-PC generation and the I-cache.
//  It buffers predicted NPCs, presents the head to the I-cache, and applies backpressure when full.

---
 rtl/npc_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/npc_queue.sv
// npc_queue: fetch-address queue between next-PC generation and the I-cache.
// Buffers predicted NPCs in local storage, presents the head to the I-cache,
// flags misaligned heads and applies backpressure when full.
// Optional feature macro: NPC_QUEUE_STATS_EN adds a saturating drop counter
// (o_drop_cnt) counting cycles where an NPC was offered while the queue was full.
module npc_queue #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 16,
  parameter int ALIGN_BITS   = 2,
  parameter int FALL_THROUGH = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_npc_valid,
  input  logic [ADDR_W-1:0]          i_npc,
  output logic                       o_npc_ready,
  input  logic                       i_inn_stall,
  input  logic                       i_flush,
  output logic                       o_icache_valid,
  output logic                       o_misalign,
  output logic [ADDR_W-1:0]          o_npc,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_usage
`ifdef NPC_QUEUE_STATS_EN
  ,
  output logic [15:0]                o_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  usage_q, usage_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic              is_empty;
  logic              is_full;
  logic              fall_through;
  logic              push;
  logic              pop;
  logic              ft_pop;
  logic              wr_en;
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;

  // Handshake decode: a push into an empty queue can bypass storage entirely
  // when fall-through is enabled and the consumer takes it in the same cycle.
  always_comb begin
    is_empty     = (usage_q == '0);
    is_full      = (usage_q == CNT_W'(DEPTH));
    fall_through = (FALL_THROUGH != 0) && is_empty && i_npc_valid && !i_flush;
    push         = i_npc_valid && !is_full && !i_flush;
    pop          = !is_empty && !i_inn_stall;
    ft_pop       = fall_through && !i_inn_stall;
    wr_en        = push && !ft_pop;
    head_valid   = !is_empty || fall_through;
    head_addr    = fall_through ? i_npc : mem_q[rd_ptr_q];
  end

  // Next-state for pointers and occupancy; flush wins over any same-cycle push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   usage_d = usage_q + 1'b1;
        2'b01:   usage_d = usage_q - 1'b1;
        default: usage_d = usage_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= i_npc;
    end
  end

  // Outputs are forced to their idle values while reset is asserted.
  always_comb begin
    o_empty        = !i_rst_n || is_empty;
    o_full         = i_rst_n && is_full;
    o_npc_ready    = !o_full;
    o_usage        = i_rst_n ? usage_q : '0;
    o_npc          = i_rst_n ? head_addr : '0;
    o_icache_valid = i_rst_n && head_valid && (head_addr[ALIGN_BITS-1:0] == '0);
    o_misalign     = i_rst_n && head_valid && (head_addr[ALIGN_BITS-1:0] != '0);
  end

`ifdef NPC_QUEUE_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of cycles where an offered NPC was refused for lack of space.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_flush) begin
      drop_cnt_d = '0;
    end else if (i_npc_valid && is_full && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule
